// File: rtl/reg_to_obi_bridge.sv
// Replays one register-bus transaction as a single OBI transaction and returns rdata and error.
// Latency: 4 cycles with zero-wait gnt/rvalid. reg_valid_i is held until the one-cycle reg_ready_o pulse.
module reg_to_obi_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic                   obi_req_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_gnt_i,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   be_q;
  logic                   we_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   error_q;
  logic                   stale_q;
  logic [CntWidth-1:0]    cnt_q;
  logic                   load;
  logic                   resp_ok;
  logic                   resp_to;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    resp_ok = 1'b0;
    resp_to = 1'b0;
    case (state_q)
      IDLE: begin
        // A timed-out transaction may still answer; hold off until it does.
        if (reg_valid_i && !stale_q) begin
          load    = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (obi_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (obi_rvalid_i) begin
          resp_ok = 1'b1;
          state_d = DONE;
        end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
          resp_to = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        addr_q  <= reg_addr_i;
        wdata_q <= reg_wdata_i;
        we_q    <= reg_write_i;
        be_q    <= reg_write_i ? reg_wstrb_i : '1;
      end
      cnt_q <= (state_q == RESP) ? cnt_q + 1'b1 : '0;
      if (resp_ok) begin
        rdata_q <= we_q ? '0 : obi_rdata_i;
        error_q <= 1'b0;
      end else if (resp_to) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end
      // The late response of a timed-out transaction is swallowed here.
      if (resp_to) begin
        stale_q <= 1'b1;
      end else if (stale_q && obi_rvalid_i) begin
        stale_q <= 1'b0;
      end
    end
  end

  assign obi_req_o   = (state_q == ADDR);
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_addr_o  = addr_q;
  assign obi_wdata_o = wdata_q;
  assign reg_ready_o = (state_q == DONE);
  assign reg_rdata_o = reg_ready_o ? rdata_q : '0;
  assign reg_error_o = reg_ready_o & error_q;

endmodule
